// File: rtl/seven_pkg.sv
// Shared parameters and state enumeration for the seven_encode bit-vector serializer.
package seven_pkg;

  localparam int N     = 128;
  localparam int IDX_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seven_penc.sv
// Combinational lowest-set-bit priority encoder: returns the index of the
// lowest set bit of vec and flags whether any bit is set at all.
module seven_penc #(
  parameter int N     = seven_pkg::N,
  parameter int IDX_W = seven_pkg::IDX_W
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_encode.sv
// Serializes a captured bit vector into ascending set-bit indices with a
// valid/ready handshake. Define SEVEN_ENCODE_COUNT_EN to add the popcount output.
module seven_encode #(
  parameter int N     = seven_pkg::N,
  parameter int IDX_W = seven_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [N-1:0]     vec_in,
  output logic             busy,
  output logic [IDX_W-1:0] idx_out,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic             done
`ifdef SEVEN_ENCODE_COUNT_EN
  ,
  output logic [IDX_W:0]   count
`endif
);

  import seven_pkg::*;

  localparam logic [N-1:0] ONE = {{(N - 1){1'b0}}, 1'b1};

  state_t             state;
  state_t             stateNext;
  logic [N-1:0]       pending;
  logic [N-1:0]       pendingNext;
  logic [N-1:0]       clearMask;
  logic [IDX_W-1:0]   lowIdx;
  logic               lowAny;

  seven_penc #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_penc (
    .vec (pending),
    .idx (lowIdx),
    .any (lowAny)
  );

  assign clearMask = ONE << lowIdx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= stateNext;
      pending <= pendingNext;
    end
  end

  // The handshake that clears the last pending bit moves straight to DONE.
  always_comb begin
    stateNext   = state;
    pendingNext = pending;
    case (state)
      IDLE: begin
        if (load) begin
          pendingNext = vec_in;
          stateNext   = (|vec_in) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (idx_ready) begin
          pendingNext = pending & ~clearMask;
          if (~|pendingNext) begin
            stateNext = DONE;
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    idx_valid = (state == SCAN) && lowAny;
    idx_out   = idx_valid ? lowIdx : '0;
    done      = (state == DONE);
  end

`ifdef SEVEN_ENCODE_COUNT_EN
  logic [IDX_W:0] loadCount;

  always_comb begin
    loadCount = '0;
    for (int i = 0; i < N; i++) begin
      loadCount = loadCount + (IDX_W + 1)'(vec_in[i]);
    end
  end

  // Popcount is captured only on an accepted load and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (state == IDLE && load) begin
      count <= loadCount;
    end
  end
`endif

endmodule

// File: tb/tb_seven_encode.sv
// Self-checking bench for seven_encode: directed and random vectors checked
// against an index-queue reference model.
module tb_seven_encode;

  localparam int N     = 128;
  localparam int IDX_W = 7;

  logic             clk;
  logic             rst;
  logic             load;
  logic [N-1:0]     vec_in;
  logic             busy;
  logic [IDX_W-1:0] idx_out;
  logic             idx_valid;
  logic             idx_ready;
  logic             done;
`ifdef SEVEN_ENCODE_COUNT_EN
  logic [IDX_W:0]   count;
`endif

  int errors = 0;
  int checks = 0;

  seven_encode #(
    .N     (N),
    .IDX_W (IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .vec_in    (vec_in),
    .busy      (busy),
    .idx_out   (idx_out),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .done      (done)
`ifdef SEVEN_ENCODE_COUNT_EN
    ,
    .count     (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [N-1:0] randomVec();
    logic [N-1:0] r;
    for (int w = 0; w < N / 32; w++) begin
      r[32*w +: 32] = $urandom & $urandom & $urandom;
    end
    return r;
  endfunction

  // Runs one complete load/scan/done transaction and checks every cycle.
  // readyMode: 0 always ready, 1 random ready, 2 stall 3 cycles on index 5.
  task automatic applyStimulus(input logic [N-1:0] v, input int readyMode, input bit noise);
    int  q[$];
    int  stalls;
    int  cycles;
    int  expCount;
    bit  rdy;
    stalls = 0;
    cycles = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) q.push_back(i);
    end
    expCount = q.size();
    load   = 1'b1;
    vec_in = v;
    @(posedge clk); #1;
    load   = 1'b0;
    vec_in = '0;
    while (q.size() > 0 && cycles < 1000) begin
      checkOutput("scan_busy", 32'(busy), 32'd1);
      checkOutput("scan_valid", 32'(idx_valid), 32'd1);
      checkOutput("scan_idx", 32'(idx_out), q[0]);
      checkOutput("scan_done", 32'(done), 32'd0);
`ifdef SEVEN_ENCODE_COUNT_EN
      checkOutput("scan_count", 32'(count), expCount);
`endif
      case (readyMode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          if (q[0] == 5 && stalls < 3) begin
            rdy = 1'b0;
            stalls++;
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
      idx_ready = rdy;
      if (noise) begin
        load   = 1'($urandom_range(0, 1));
        vec_in = randomVec() | 128'hFF;
      end
      @(posedge clk); #1;
      cycles++;
      if (rdy) void'(q.pop_front());
    end
    if (cycles >= 1000) checkOutput("scan_timeout", 32'd0, 32'd1);
    idx_ready = 1'b0;
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("done_busy", 32'(busy), 32'd1);
    checkOutput("done_valid", 32'(idx_valid), 32'd0);
    checkOutput("done_idx", 32'(idx_out), 32'd0);
    load   = 1'b1;
    vec_in = '1;
    @(posedge clk); #1;
    load   = 1'b0;
    vec_in = '0;
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_valid", 32'(idx_valid), 32'd0);
`ifdef SEVEN_ENCODE_COUNT_EN
    checkOutput("idle_count", 32'(count), expCount);
`endif
  endtask

  initial begin
    logic [N-1:0] v;
    rst       = 1'b1;
    load      = 1'b0;
    vec_in    = '0;
    idx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(idx_valid), 32'd0);
    checkOutput("rst_idx", 32'(idx_out), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
`ifdef SEVEN_ENCODE_COUNT_EN
    checkOutput("rst_count", 32'(count), 32'd0);
`endif
    rst = 1'b0;

    $display("[TB] single bit");
    applyStimulus(128'h1, 0, 1'b0);

    $display("[TB] sparse {0,5,127}");
    v = '0;
    v[0] = 1'b1; v[5] = 1'b1; v[N-1] = 1'b1;
    applyStimulus(v, 0, 1'b0);

    $display("[TB] backpressure on index 5");
    applyStimulus(v, 2, 1'b0);

    $display("[TB] empty vector");
    applyStimulus('0, 0, 1'b0);

    $display("[TB] load during scan ignored");
    applyStimulus(v, 0, 1'b1);

    $display("[TB] reset mid-scan");
    load   = 1'b1;
    vec_in = 128'h5;
    @(posedge clk); #1;
    load   = 1'b0;
    vec_in = '0;
    checkOutput("pre_rst_idx", 32'(idx_out), 32'd0);
    checkOutput("pre_rst_valid", 32'(idx_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_valid", 32'(idx_valid), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    checkOutput("mid_rst_idx", 32'(idx_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef SEVEN_ENCODE_COUNT_EN
    checkOutput("mid_rst_count", 32'(count), 32'd0);
`endif
    applyStimulus(128'h30, 0, 1'b0);

`ifdef SEVEN_ENCODE_COUNT_EN
    $display("[TB] all ones with count");
    applyStimulus('1, 0, 1'b0);
`endif

    $display("[TB] random vectors");
    for (int n = 0; n < 20; n++) begin
      v = randomVec();
      if ($urandom_range(0, 3) == 0) v[N-1] = 1'b1;
      applyStimulus(v, 1, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_encode.md
SEVEN_ENCODE -- requirements
Module: seven_encode

Interface
REQ-001 SHALL have parameter N, default 128, meaning the request vector width.
REQ-002 SHALL have parameter IDX_W, default 7, meaning the index width; N SHALL equal 2**IDX_W.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port load  input  1  capture vec_in and start a scan.
REQ-006 SHALL have port vec_in  input  N  bit vector to be serialized.
REQ-007 SHALL have port busy  output  1  high while a scan is in progress (state not IDLE).
REQ-008 SHALL have port idx_out  output  IDX_W  index of the current lowest set pending bit.
REQ-009 SHALL have port idx_valid  output  1  idx_out is valid.
REQ-010 SHALL have port idx_ready  input  1  consumer accepts idx_out.
REQ-011 SHALL have port done  output  1  one-cycle pulse at scan completion.

Function
REQ-012 SHALL implement states IDLE, SCAN and DONE.
REQ-013 SHALL, in IDLE with load=1, register vec_in into a pending register at that edge and enter SCAN, or enter DONE if vec_in==0.
REQ-014 SHALL ignore load while state is SCAN or DONE, leaving pending unchanged.
REQ-015 SHALL, in SCAN, drive idx_valid=1 and idx_out=lowest-index set bit of pending; first index visible at cycle t+1 for load at cycle t.
REQ-016 SHALL, on idx_valid and idx_ready at an edge, clear that bit of pending; the next index SHALL be presented in the following cycle (one index per cycle at full throughput).
REQ-017 SHALL hold idx_out and idx_valid stable while idx_ready=0 (no drop, no skip).
REQ-018 SHALL transition SCAN to DONE on the handshake that clears the last set bit.
REQ-019 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE; load in that cycle is ignored.
REQ-020 SHALL drive idx_valid=0 and idx_out=0 outside SCAN.
REQ-021 SHALL emit indices in strictly ascending order, bit N-1 included (no wrap past N-1).

Reset
REQ-022 SHALL, on rst=1 at any time including mid-scan, immediately force state=IDLE, pending=0, busy=0, idx_valid=0, idx_out=0 and done=0.
REQ-023 SHALL accept load on the first rising edge after rst deasserts.

Configuration
REQ-024 SHALL, with SEVEN_ENCODE_COUNT_EN defined, add output count (IDX_W+1 bits), registered popcount of vec_in at each accepted load, holding until the next accepted load, reset value 0.
REQ-025 SHALL, without SEVEN_ENCODE_COUNT_EN, omit the count port and its logic entirely, leaving all other behaviour identical.

Structure
REQ-026 SHALL take N, IDX_W and the state enumeration from shared package seven_pkg.
REQ-027 SHALL instantiate one combinational sub-module seven_penc (N-to-IDX_W lowest-set-bit priority encoder with any-set flag), used for idx_out and last-bit detection.

Verification
REQ-028 SHALL verify reset: rst pulsed mid-SCAN with pending=128'h5 -> busy, idx_valid, done and idx_out all 0 in the same cycle; subsequent IDLE load accepted.
REQ-029 SHALL verify single bit: load vec_in=128'h1, idx_ready=1 -> idx_out=0 valid at t+1, done=1 at t+2, busy=0 at t+3.
REQ-030 SHALL verify sparse: vec_in bits {0,5,127}, idx_ready=1 -> idx_out 0,5,127 on t+1..t+3, done at t+4.
REQ-031 SHALL verify backpressure: same vector with idx_ready=0 for 3 cycles while idx_out=5 -> idx_out=5 held 4 cycles, no index lost or repeated.
REQ-032 SHALL verify empty and busy-load: load vec_in=0 -> no idx_valid, done at t+1; load 128'hFF asserted during SCAN -> ignored, original sequence completes.
REQ-033 SHALL verify count, with SEVEN_ENCODE_COUNT_EN: load all-ones -> count=128 at t+1, 128 indices 0..127 emitted, done at t+129.
